tdc_therm_decoder: RTL and testbench
====================================

Name: tdc_therm_decoder

Overview:
- Downstream stage of the TDC delay line. Arms on request, synchronises the start event, and waits a fixed settle time. It then captures the N_DELAY-bit thermometer tap vector, applies bubble correction, and converts it to a binary tap count.
- The result goes out on a valid/ready interface with overflow and zero flags.
- Replaces the raw 32-bit register and byte-select path in the TDC top with a single calibrated code.

Parameters:
- N_DELAY, 32, number of delay-line taps (width of therm_i); must be ≥ 4.
- OUT_W, 6, width of code_o; must satisfy 2^OUT_W > N_DELAY.
- SETTLE_CYC, 2, clk cycles waited after the detected start edge before capture; must be ≥ 1.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- therm_i, input, N_DELAY, raw thermometer taps from tdc_delay; bit 0 is the first tap.
- arm_i, input, 1, request one measurement; sampled only in IDLE.
- start_i, input, 1, asynchronous start event; synchronised internally.
- code_o, output, OUT_W, count of corrected ones in the captured vector.
- valid_o, output, 1, code_o/ovf_o/zero_o are valid.
- ready_i, input, 1, consumer accepts the result when valid_o & ready_i.
- ovf_o, output, 1, corrected vector is all ones (event outran the line).
- zero_o, output, 1, corrected vector is all zeros.
- busy_o, output, 1, FSM is not in IDLE.
- drop_cnt_o, output, 8, saturating count of arm_i pulses ignored while not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM returns to IDLE; synchroniser flops clear.
  - code_o=0, valid_o=0, ovf_o=0, zero_o=0, busy_o=0, drop_cnt_o=0.
  - Reset mid-measurement discards everything in flight, with no partial output.
- Start path:
  - start_i passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - edge = s2 & ~s3.
  - Synchroniser and s3 run in every state, so an edge present before arming is not remembered.
- FSM states:
  - IDLE: on arm_i=1 → ARMED.
  - ARMED: on edge=1 → SETTLE; load settle counter with SETTLE_CYC-1.
  - SETTLE: counter decrements each cycle. At the edge where counter==0, therm_i is registered into cap_q → DECODE.
  - DECODE: correction and popcount on cap_q are registered into code_o/ovf_o/zero_o; valid_o set → OUTPUT.
  - OUTPUT: all outputs held stable while valid_o & ~ready_i. On valid_o & ready_i, valid_o clears at that edge → IDLE. A new arm_i is not accepted in the same cycle.
- busy_o = (state != IDLE).
- drop_cnt_o: increments on each cycle with arm_i=1 while state != IDLE; saturates at 255 and never wraps.
- Bubble correction:
  - c[i] = majority(t[i-1], t[i], t[i+1]), where t is cap_q, t[-1]=1 and t[N_DELAY]=0.
  - code_o = number of ones in c, range 0..N_DELAY.
  - ovf_o = (code_o == N_DELAY); zero_o = (code_o == 0). Both are registered with code_o.
- Latency:
  - start_i rises before clock edge E0 with arm already accepted; edge is high after E1.
  - FSM leaves ARMED at E2 and therm_i is captured at E(2+SETTLE_CYC).
  - valid_o goes high after E(3+SETTLE_CYC). With the defaults, that is after E5.
- Start while IDLE or OUTPUT: ignored, not queued.
- ready_i high in the same cycle valid_o rises: the handshake completes at the next edge, so valid_o is high for exactly 1 cycle.

Test Plan:
- Reset values: assert rst_n=0 mid-SETTLE, release → all outputs 0, state IDLE; next arm+start measures normally.
- Clean code: N_DELAY=32, therm_i=32'h0000_03FF, arm, start, ready_i=1 → code_o=10, ovf_o=0, zero_o=0. valid_o rises 5 edges after start is first sampled and is high for 1 cycle.
- Bubble: therm_i=32'h0000_0BFF → code_o=11. therm_i=32'h0000_01FD (single 0 bubble at bit 1) → code_o=9.
- Boundaries: therm_i=32'hFFFF_FFFF → code_o=32, ovf_o=1. therm_i=0 → code_o=0, zero_o=1.
- Backpressure: ready_i=0 for 10 cycles after valid_o; change therm_i and pulse start → code_o/flags stable, valid_o stays 1. Then ready_i=1 → valid_o=0 at the next edge, busy_o=0.
- Drop counter: pulse arm_i 3 times while in OUTPUT → drop_cnt_o=3. Hold arm_i high while busy for 300 cycles → drop_cnt_o=255 and stays 255.

Source files
------------

// File: rtl/tdc_therm_decoder_if.sv
// Result channel of the TDC thermometer decoder: calibrated tap count plus
// flags, moved with a valid/ready handshake.
interface tdc_therm_decoder_if #(
  parameter int OUT_W = 6
);
  logic [OUT_W-1:0] code_o;
  logic             valid_o;
  logic             ready_i;
  logic             ovf_o;
  logic             zero_o;

  modport master (
    output code_o,
    output valid_o,
    output ovf_o,
    output zero_o,
    input  ready_i
  );

  modport slave (
    input  code_o,
    input  valid_o,
    input  ovf_o,
    input  zero_o,
    output ready_i
  );
endinterface

// File: rtl/tdc_therm_decoder.sv
// TDC delay-line back end: arm, synchronise start, settle, capture taps,
// bubble-correct and popcount into a tap count on a valid/ready channel.
module tdc_therm_decoder #(
  parameter int N_DELAY    = 32,
  parameter int OUT_W      = 6,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DELAY-1:0] therm_i,
  input  logic               arm_i,
  input  logic               start_i,
  tdc_therm_decoder_if.master res,
  output logic               busy_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_DECODE,
    ST_OUTPUT
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_DELAY-1:0] cap_reg;
  logic [OUT_W-1:0]   code_reg;
  logic               valid_reg;
  logic               ovf_reg;
  logic               zero_reg;
  logic [7:0]         drop_reg;

  logic               s1_reg;
  logic               s2_reg;
  logic               s3_reg;
  logic               start_edge;

  logic [N_DELAY+1:0] ext_vec;
  logic [N_DELAY-1:0] corr_vec;
  logic [OUT_W-1:0]   pop_next;

  // The synchroniser runs in every state so a start seen before arming
  // has already been consumed by the time ARMED looks for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= start_i;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign start_edge = s2_reg & ~s3_reg;

  // Pad the captured taps with a virtual 1 below tap 0 and a virtual 0
  // above the last tap so the end taps get a full three-tap vote.
  assign ext_vec = {1'b0, cap_reg, 1'b1};

  generate
    for (genvar gi = 0; gi < N_DELAY; gi++) begin : g_bubble
      assign corr_vec[gi] = (ext_vec[gi] & ext_vec[gi+1]) |
                            (ext_vec[gi] & ext_vec[gi+2]) |
                            (ext_vec[gi+1] & ext_vec[gi+2]);
    end
  endgenerate

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      pop_next = pop_next + OUT_W'(corr_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cap_reg   <= '0;
      code_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arm_i) begin
            state_reg <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (start_edge) begin
            cnt_reg   <= CNT_W'(SETTLE_CYC - 1);
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            cap_reg   <= therm_i;
            state_reg <= ST_DECODE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_DECODE: begin
          code_reg  <= pop_next;
          ovf_reg   <= (pop_next == OUT_W'(N_DELAY));
          zero_reg  <= (pop_next == '0);
          valid_reg <= 1'b1;
          state_reg <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          // Result stays frozen until the consumer takes it.
          if (res.ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Arm requests arriving while a measurement is in flight are counted,
  // saturating so a stuck arm line cannot wrap back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_reg <= 8'd0;
    end else if (arm_i && (state_reg != ST_IDLE) && (drop_reg != 8'hFF)) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  assign res.code_o  = code_reg;
  assign res.valid_o = valid_reg;
  assign res.ovf_o   = ovf_reg;
  assign res.zero_o  = zero_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign drop_cnt_o  = drop_reg;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed bench for tdc_therm_decoder: vector table of tap patterns plus
// hand-written reset, pre-arm, backpressure and drop-counter sequences.
module tb_tdc_therm_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] therm_i;
  logic        arm_i;
  logic        start_i;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  int n_cmp;
  int n_bad;

  tdc_therm_decoder_if #(.OUT_W(6)) res_if ();

  tdc_therm_decoder #(
    .N_DELAY   (32),
    .OUT_W     (6),
    .SETTLE_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .therm_i   (therm_i),
    .arm_i     (arm_i),
    .start_i   (start_i),
    .res       (res_if),
    .busy_o    (busy_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] therm;
    logic [5:0]  code;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One measurement: taps read as ~val except in the single cycle that
  // should be captured, so a mistimed capture gives a wrong code.
  task automatic measure(input logic [31:0] val, input logic [5:0] ecode,
                         input logic eovf, input logic ezero,
                         input logic do_arm, input logic rdy);
    int n;
    res_if.ready_i = rdy;
    therm_i = ~val;
    if (do_arm) begin
      arm_i = 1'b1;
      @(posedge clk); #1;
      arm_i = 1'b0;
    end
    start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 2) start_i = 1'b0;
      if (n == 4) therm_i = val;
      if (n == 5) therm_i = ~val;
    end while (res_if.valid_o !== 1'b1 && n < 40);
    check("latency", n, 6);
    check("code", {26'd0, res_if.code_o}, {26'd0, ecode});
    check("ovf", {31'd0, res_if.ovf_o}, {31'd0, eovf});
    check("zero", {31'd0, res_if.zero_o}, {31'd0, ezero});
    $display("txn therm=%08h code=%0d ovf=%0b zero=%0b edges=%0d",
             val, res_if.code_o, res_if.ovf_o, res_if.zero_o, n);
    if (rdy) begin
      @(posedge clk); #1;
      check("valid_one_cycle", {31'd0, res_if.valid_o}, 32'd0);
      check("busy_after_hs", {31'd0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    therm_i = 32'd0;
    arm_i = 1'b0;
    start_i = 1'b0;
    res_if.ready_i = 1'b1;

    vecs[0] = '{32'h0000_03FF, 6'd10, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0BFF, 6'd11, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_01FD, 6'd9,  1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 6'd32, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 6'd0,  1'b0, 1'b1};
    vecs[5] = '{32'h0000_0002, 6'd1,  1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 6'd0,  1'b0, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 6'd31, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_F00F, 6'd8,  1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_code", {26'd0, res_if.code_o}, 32'd0);
    check("rst_valid", {31'd0, res_if.valid_o}, 32'd0);
    check("rst_ovf", {31'd0, res_if.ovf_o}, 32'd0);
    check("rst_zero", {31'd0, res_if.zero_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      measure(vecs[i].therm, vecs[i].code, vecs[i].ovf, vecs[i].zero, 1'b1, 1'b1);
    end

    // Start edge seen while idle must not trigger a later measurement
    therm_i = 32'h0000_03FF;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arm_i = 1'b1;
    @(posedge clk); #1;
    arm_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("prearm_no_valid", {31'd0, res_if.valid_o}, 32'd0);
    check("prearm_busy", {31'd0, busy_o}, 32'd1);
    measure(32'h0000_03FF, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of SETTLE
    therm_i = 32'h0000_00FF;
    arm_i = 1'b1;
    @(posedge clk); #1;
    arm_i = 1'b0;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b0;
    check("settle_busy", {31'd0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_code", {26'd0, res_if.code_o}, 32'd0);
    check("midrst_valid", {31'd0, res_if.valid_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_output", {31'd0, res_if.valid_o}, 32'd0);
    check("midrst_idle", {31'd0, busy_o}, 32'd0);
    measure(32'h0000_0BFF, 6'd11, 1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure: result frozen, extra starts and arms ignored
    measure(32'hFFFF_FFFF, 6'd32, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      therm_i = $urandom;
      start_i = (i % 3 == 0);
      @(posedge clk); #1;
      check("bp_valid", {31'd0, res_if.valid_o}, 32'd1);
      check("bp_code", {26'd0, res_if.code_o, res_if.ovf_o, res_if.zero_o} >> 2,
            {26'd0, 6'd32});
    end
    start_i = 1'b0;
    check("bp_flags", {30'd0, res_if.ovf_o, res_if.zero_o}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      arm_i = 1'b1;
      @(posedge clk); #1;
      arm_i = 1'b0;
      @(posedge clk); #1;
    end
    check("drop_3", {24'd0, drop_cnt_o}, 32'd3);
    arm_i = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("drop_sat", {24'd0, drop_cnt_o}, 32'd255);
    repeat (5) @(posedge clk);
    #1;
    check("drop_hold", {24'd0, drop_cnt_o}, 32'd255);
    arm_i = 1'b0;
    check("bp_still_valid", {31'd0, res_if.valid_o}, 32'd1);
    res_if.ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, res_if.valid_o}, 32'd0);
    check("bp_release_busy", {31'd0, busy_o}, 32'd0);
    $display("txn backpressure release code=%0d drop=%0d", res_if.code_o, drop_cnt_o);
    repeat (8) @(posedge clk);
    #1;
    check("no_queued_start", {31'd0, busy_o | res_if.valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
